// File: rtl/uart_regs_pkg.sv
// Register map, CTRL field layout, ID word and read FSM state for the
// APB UART control/status register file.
package uart_regs_pkg;

  // Byte offsets inside the decoded APB window.
  localparam int OFF_DIV     = 'h00;
  localparam int OFF_CTRL    = 'h04;
  localparam int OFF_STATUS  = 'h08;
  localparam int OFF_IRQ_EN  = 'h0C;
  localparam int OFF_ERR_CNT = 'h10;  // ERR_CNT[i] lives at OFF_ERR_CNT + 4*i
  localparam int OFF_ID      = 'h30;

  // CTRL register layout.
  localparam int CTRL_W          = 6;
  localparam int CTRL_PARITY_LSB = 0;  // 3-bit parity mode
  localparam int CTRL_STOP_BIT   = 3;
  localparam int CTRL_TX_EN_BIT  = 4;
  localparam int CTRL_RX_EN_BIT  = 5;

  localparam logic [15:0] ID_MAGIC = 16'h0A17;

  // ID word: magic in the upper half, then the build configuration.
  function automatic logic [31:0] id_word(input int num_err, input int cnt_w);
    return {ID_MAGIC, 8'(num_err), 8'(cnt_w)};
  endfunction

  typedef enum logic {
    ST_IDLE,
    ST_RD_WAIT
  } rd_state_t;

endpackage

// File: rtl/uart_err_counter.sv
// Saturating per-source error counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : one-cycle error event, adds one (sticks at all-ones)
//   clr        : clear request; a simultaneous inc leaves the count at 1
//   count      : current count
module uart_err_counter
  import uart_regs_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= inc ? CNT_W'(1) : '0;
    end else if (inc && count != '1) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/apb_uart_regfile.sv
// APB register file for a UART: baud divisor, line control, sticky error
// status with interrupt enables, per-source saturating error counters, ID.
//   clk, rst_n                    : clock, asynchronous active-low reset
//   psel/penable/pwrite/paddr/pwdata : APB request
//   prdata/pready/pslverr         : APB response (writes: zero wait,
//                                   reads: one wait state)
//   err_evt                       : one-cycle error pulses from rx/tx
//   div, parity_mode, stop_bits, tx_en, rx_en : configuration outputs
//   irq                           : registered |(STATUS & IRQ_EN)
module apb_uart_regfile
  import uart_regs_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int DIV_W   = 16,
  parameter int DIV_RST = 868,
  parameter int NUM_ERR = 3,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               psel,
  input  logic               penable,
  input  logic               pwrite,
  input  logic [31:0]        paddr,
  input  logic [31:0]        pwdata,
  output logic [31:0]        prdata,
  output logic               pready,
  output logic               pslverr,
  input  logic [NUM_ERR-1:0] err_evt,
  output logic [DIV_W-1:0]   div,
  output logic [2:0]         parity_mode,
  output logic               stop_bits,
  output logic               tx_en,
  output logic               rx_en,
  output logic               irq
);

  logic [CTRL_W-1:0]  ctrl;
  logic [NUM_ERR-1:0] status;
  logic [NUM_ERR-1:0] irq_en;
  logic [CNT_W-1:0]   cnt [NUM_ERR];

  rd_state_t state;
  logic      rd_err;

  logic [ADDR_W-1:0]  off;
  logic               hit_div, hit_ctrl, hit_status, hit_irq_en, hit_id, hit_cnt;
  logic [NUM_ERR-1:0] cnt_sel;
  logic               bad;
  logic [31:0]        rdata_next;

  // Only the low ADDR_W address bits and the used data bits matter.
  logic unused_bits;
  assign unused_bits = ^{paddr, pwdata};

  assign off = paddr[ADDR_W-1:0];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    hit_div    = (off == ADDR_W'(OFF_DIV));
    hit_ctrl   = (off == ADDR_W'(OFF_CTRL));
    hit_status = (off == ADDR_W'(OFF_STATUS));
    hit_irq_en = (off == ADDR_W'(OFF_IRQ_EN));
    hit_id     = (off == ADDR_W'(OFF_ID));
    cnt_sel    = '0;
    for (int i = 0; i < NUM_ERR; i++) begin
      cnt_sel[i] = (off == ADDR_W'(OFF_ERR_CNT + 4 * i));
    end
    hit_cnt = |cnt_sel;

    bad = (paddr[1:0] != 2'b00)
        | ~(hit_div | hit_ctrl | hit_status | hit_irq_en | hit_id | hit_cnt)
        | (pwrite & hit_id);

    rdata_next = '0;
    if (hit_div)    rdata_next = 32'(div);
    if (hit_ctrl)   rdata_next = 32'(ctrl);
    if (hit_status) rdata_next = 32'(status);
    if (hit_irq_en) rdata_next = 32'(irq_en);
    if (hit_id)     rdata_next = id_word(NUM_ERR, CNT_W);
    for (int i = 0; i < NUM_ERR; i++) begin
      if (cnt_sel[i]) rdata_next = 32'(cnt[i]);
    end
  end

  logic access, idle, wr_ok, rd_start;
  assign access   = psel & penable;
  assign idle     = (state == ST_IDLE);
  assign wr_ok    = access & pwrite & idle & ~bad;
  assign rd_start = access & ~pwrite & idle;

  // Writes finish in their first access cycle; reads finish in RD_WAIT.
  // The idle term keeps pready low right after a reset that aborted a read.
  assign pready  = access & (idle ? pwrite : 1'b1);
  assign pslverr = pready & (idle ? bad : rd_err);

  // Read FSM: capture data and the error flag in the first access cycle.
  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      prdata <= '0;
      rd_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rd_start) begin
            prdata <= rdata_next;
            rd_err <= bad;
            state  <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  logic [NUM_ERR-1:0] w1c;
  assign w1c = (wr_ok && hit_status) ? pwdata[NUM_ERR-1:0] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div    <= DIV_W'(DIV_RST);
      ctrl   <= '0;
      status <= '0;
      irq_en <= '0;
      irq    <= 1'b0;
    end else begin
      if (wr_ok && hit_div)    div    <= pwdata[DIV_W-1:0];
      if (wr_ok && hit_ctrl)   ctrl   <= pwdata[CTRL_W-1:0];
      if (wr_ok && hit_irq_en) irq_en <= pwdata[NUM_ERR-1:0];
      // New events are ORed in after the clear so a coincident set wins.
      status <= (status & ~w1c) | err_evt;
      irq    <= |(status & irq_en);
    end
  end

  for (genvar g = 0; g < NUM_ERR; g++) begin : g_err_cnt
    uart_err_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (err_evt[g]),
      .clr   (wr_ok & cnt_sel[g]),
      .count (cnt[g])
    );
  end

  assign parity_mode = ctrl[CTRL_PARITY_LSB +: 3];
  assign stop_bits   = ctrl[CTRL_STOP_BIT];
  assign tx_en       = ctrl[CTRL_TX_EN_BIT];
  assign rx_en       = ctrl[CTRL_RX_EN_BIT];

endmodule

// File: tb/tb_apb_uart_regfile.sv
// Self-checking bench for apb_uart_regfile with default parameters.
// A register-level reference model tracks DIV/CTRL/STATUS/IRQ_EN/counters.
module tb_apb_uart_regfile;

  localparam int NUM_ERR = 3;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic [2:0]  err_evt = '0;
  logic [15:0] div;
  logic [2:0]  parity_mode;
  logic        stop_bits, tx_en, rx_en, irq;

  int checks = 0;
  int errors = 0;

  apb_uart_regfile dut (
    .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .err_evt(err_evt), .div(div), .parity_mode(parity_mode),
    .stop_bits(stop_bits), .tx_en(tx_en), .rx_en(rx_en), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  int m_div, m_ctrl, m_status, m_irq_en;
  int m_cnt [NUM_ERR];
  localparam logic [31:0] ID_EXP = 32'h0A17_0000 | (NUM_ERR << 8) | CNT_W;

  function automatic void model_reset();
    m_div = 868; m_ctrl = 0; m_status = 0; m_irq_en = 0;
    for (int i = 0; i < NUM_ERR; i++) m_cnt[i] = 0;
  endfunction

  function automatic void model_events(input int evt);
    for (int i = 0; i < NUM_ERR; i++) begin
      if ((evt >> i) & 1) begin
        m_status |= (1 << i);
        if (m_cnt[i] < CNT_MAX) m_cnt[i]++;
      end
    end
  endfunction

  function automatic bit model_bad(input int addr, input bit wr);
    int o = addr & 'hFFF;
    bit mapped = (o == 'h00) || (o == 'h04) || (o == 'h08) || (o == 'h0C) ||
                 (o == 'h30) || (o >= 'h10 && o < 'h10 + 4 * NUM_ERR);
    return ((addr & 3) != 0) || !mapped || (wr && o == 'h30);
  endfunction

  function automatic int model_read(input int addr);
    int o = addr & 'hFFF;
    if (model_bad(addr, 1'b0)) return 0;
    case (o)
      'h00: return m_div;
      'h04: return m_ctrl;
      'h08: return m_status;
      'h0C: return m_irq_en;
      'h30: return ID_EXP;
      default: return m_cnt[(o - 'h10) / 4];
    endcase
  endfunction

  // Register updates first, then the cycle's events: sets beat clears and a
  // cleared counter with a coincident event ends at 1.
  function automatic void model_write(input int addr, input int data, input int evt);
    int o = addr & 'hFFF;
    if (!model_bad(addr, 1'b1)) begin
      case (o)
        'h00: m_div = data & 'hFFFF;
        'h04: m_ctrl = data & 'h3F;
        'h08: m_status &= ~data;
        'h0C: m_irq_en = data & 'h7;
        default: m_cnt[(o - 'h10) / 4] = 0;
      endcase
    end
    model_events(evt);
  endfunction

  // ---------------- bus driver ----------------
  task automatic apb(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                     input logic [2:0] evt, output logic [31:0] rdata,
                     output logic err, output int cycles);
    @(posedge clk); #1;
    psel = 1; penable = 0; pwrite = wr; paddr = addr; pwdata = data;
    @(posedge clk); #1;
    penable = 1; err_evt = evt;
    cycles = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      cycles++;
      if (pready === 1'b1) break;
      @(posedge clk); #1;
      err_evt = '0;
    end
    if (pready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL apb_timeout addr=%08h: pready never rose", addr);
    end
    rdata = prdata;
    err = pslverr;
    @(posedge clk); #1;
    psel = 0; penable = 0; pwrite = 0; err_evt = '0;
    if (wr) model_write(addr, data, evt);
    else    model_events(evt);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag);
    logic [22:0] got, exp;
    got = {div, parity_mode, stop_bits, tx_en, rx_en};
    exp = {16'(m_div), 3'(m_ctrl & 7), 1'((m_ctrl >> 3) & 1),
           1'((m_ctrl >> 4) & 1), 1'((m_ctrl >> 5) & 1)};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s_outputs: got %06h expected %06h", tag, got, exp);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] rd; logic err; int cyc;
    model_reset();
    rst_n = 0;
    idle(3);
    check_outputs("reset");
    checks++;
    if ({irq, pready, pslverr, prdata} !== 35'd0) begin
      errors++;
      $display("FAIL reset_bus: irq=%b pready=%b pslverr=%b prdata=%08h expected all 0",
               irq, pready, pslverr, prdata);
    end
    rst_n = 1;
    apb(0, 32'h00, 0, 0, rd, err, cyc);
    checks++;
    if (rd !== 32'd868 || cyc !== 2 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_read_div: data=%0d cycles=%0d err=%b expected 868/2/0", rd, cyc, err);
    end
    apb(0, 32'h04, 0, 0, rd, err, cyc);
    checks++;
    if (rd !== 32'd0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_read_ctrl: data=%08h err=%b expected 0/0", rd, err);
    end
  endtask

  task automatic test_ctrl();
    logic [31:0] rd; logic err; int cyc;
    apb(1, 32'h04, 32'h3B, 0, rd, err, cyc);
    checks++;
    if (err !== 1'b0 || cyc !== 1) begin
      errors++;
      $display("FAIL ctrl_write: err=%b cycles=%0d expected 0/1", err, cyc);
    end
    check_outputs("ctrl");
  endtask

  task automatic test_random_rw();
    logic [31:0] rd, wd; logic err; int cyc;
    int regs [3] = '{'h00, 'h04, 'h0C};
    for (int n = 0; n < 24; n++) begin
      int a = regs[$urandom_range(0, 2)];
      wd = $urandom;
      apb(1, a, wd, 0, rd, err, cyc);
      checks++;
      if (err !== 1'b0 || cyc !== 1) begin
        errors++;
        $display("FAIL rw_write_%0h: err=%b cycles=%0d expected 0/1", a, err, cyc);
      end
      // Upper address bits beyond the decoded window must not matter.
      apb(0, a | ($urandom & 32'hFFFF_F000), 0, 0, rd, err, cyc);
      checks++;
      if (rd !== 32'(model_read(a)) || cyc !== 2) begin
        errors++;
        $display("FAIL rw_read_%0h: data=%08h cycles=%0d expected %08h/2",
                 a, rd, cyc, model_read(a));
      end
    end
    check_outputs("rw");
  endtask

  task automatic test_status_irq();
    logic [31:0] rd; logic err; int cyc;
    apb(1, 32'h08, 32'h7, 0, rd, err, cyc);   // start from clean status
    apb(1, 32'h0C, 32'h4, 0, rd, err, cyc);
    idle(2);
    @(posedge clk); #1 err_evt = 3'b100;
    @(posedge clk); #1 err_evt = 3'b000;
    model_events(3'b100);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_latency_early: irq=%b expected 0", irq);
    end
    @(posedge clk); #1;
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_latency: irq=%b expected 1", irq);
    end
    apb(0, 32'h08, 0, 0, rd, err, cyc);
    checks++;
    if (rd !== 32'(m_status)) begin
      errors++;
      $display("FAIL status_set: data=%08h expected %08h", rd, m_status);
    end
    apb(1, 32'h08, 32'h4, 3'b100, rd, err, cyc);   // clear races a new event
    apb(0, 32'h08, 0, 0, rd, err, cyc);
    checks++;
    if (rd !== 32'(m_status) || rd !== 32'h4) begin
      errors++;
      $display("FAIL status_set_wins: data=%08h expected %08h", rd, m_status);
    end
    apb(1, 32'h08, 32'hFFFF_FFFF, 0, rd, err, cyc);
    apb(0, 32'h08, 0, 0, rd, err, cyc);
    idle(2);
    checks++;
    if (rd !== 32'd0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL status_w1c: data=%08h irq=%b expected 0/0", rd, irq);
    end
  endtask

  task automatic test_counters();
    logic [31:0] rd; logic err; int cyc;
    apb(1, 32'h0C, $urandom, 0, rd, err, cyc);
    for (int n = 0; n < 60; n++) begin
      @(posedge clk); #1;
      err_evt = 3'($urandom_range(0, 7));
      model_events(err_evt);
    end
    @(posedge clk); #1 err_evt = '0;
    idle(2);
    for (int a = 'h08; a <= 'h18; a += 4) begin
      apb(0, a, 0, 0, rd, err, cyc);
      checks++;
      if (rd !== 32'(model_read(a))) begin
        errors++;
        $display("FAIL cnt_random_%0h: data=%08h expected %08h", a, rd, model_read(a));
      end
    end
    checks++;
    if (irq !== 1'(((m_status & m_irq_en) != 0))) begin
      errors++;
      $display("FAIL cnt_irq: irq=%b expected %b", irq, (m_status & m_irq_en) != 0);
    end
    apb(1, 32'h10, 0, 0, rd, err, cyc);
    for (int n = 0; n < 300; n++) begin
      @(posedge clk); #1 err_evt = 3'b001;
      model_events(1);
    end
    @(posedge clk); #1 err_evt = '0;
    apb(0, 32'h10, 0, 0, rd, err, cyc);
    checks++;
    if (rd !== 32'(CNT_MAX) || rd !== 32'(m_cnt[0])) begin
      errors++;
      $display("FAIL cnt_saturate: data=%0d expected %0d", rd, m_cnt[0]);
    end
    apb(1, 32'h10, $urandom, 3'b001, rd, err, cyc);
    apb(0, 32'h10, 0, 0, rd, err, cyc);
    checks++;
    if (rd !== 32'd1 || rd !== 32'(m_cnt[0])) begin
      errors++;
      $display("FAIL cnt_clear_with_event: data=%0d expected %0d", rd, m_cnt[0]);
    end
    apb(1, 32'h18, 0, 0, rd, err, cyc);
    apb(0, 32'h18, 0, 0, rd, err, cyc);
    checks++;
    if (rd !== 32'd0) begin
      errors++;
      $display("FAIL cnt_clear: data=%0d expected 0", rd);
    end
  endtask

  task automatic test_slverr();
    logic [31:0] rd; logic err; int cyc;
    bit          wr_l [5] = '{1, 0, 1, 0, 1};
    logic [31:0] ad_l [5] = '{32'h30, 32'h44, 32'h06, 32'h0A, 32'h1C};
    for (int n = 0; n < 5; n++) begin
      apb(wr_l[n], ad_l[n], 32'hFFFF_FFFF, 0, rd, err, cyc);
      checks++;
      if (err !== 1'b1 || cyc !== (wr_l[n] ? 1 : 2)) begin
        errors++;
        $display("FAIL slverr_%0h: err=%b cycles=%0d expected 1/%0d",
                 ad_l[n], err, cyc, wr_l[n] ? 1 : 2);
      end
    end
    for (int a = 'h00; a <= 'h18; a += 4) begin
      apb(0, a, 0, 0, rd, err, cyc);
      checks++;
      if (rd !== 32'(model_read(a)) || err !== 1'b0) begin
        errors++;
        $display("FAIL slverr_unchanged_%0h: data=%08h err=%b expected %08h/0",
                 a, rd, err, model_read(a));
      end
    end
    apb(0, 32'h30, 0, 0, rd, err, cyc);
    checks++;
    if (rd !== ID_EXP || err !== 1'b0) begin
      errors++;
      $display("FAIL id_read: data=%08h err=%b expected %08h/0", rd, err, ID_EXP);
    end
    check_outputs("slverr");
  endtask

  task automatic test_reset_rd_wait();
    logic [31:0] rd; logic err; int cyc; int strays;
    apb(1, 32'h00, 32'h1234, 0, rd, err, cyc);
    apb(1, 32'h04, 32'h3F, 0, rd, err, cyc);
    apb(1, 32'h0C, 32'h7, 3'b010, rd, err, cyc);
    idle(2);
    @(posedge clk); #1;
    psel = 1; penable = 0; pwrite = 0; paddr = 32'h00;
    @(posedge clk); #1 penable = 1;
    @(negedge clk);
    checks++;
    if (pready !== 1'b0) begin
      errors++;
      $display("FAIL rdwait_first_cycle: pready=%b expected 0", pready);
    end
    @(posedge clk); #2;         // now in the wait cycle, bus still held
    rst_n = 0;
    model_reset();
    #1;
    check_outputs("rdwait_reset");
    checks++;
    if ({irq, pready, pslverr, prdata} !== 35'd0) begin
      errors++;
      $display("FAIL rdwait_reset_bus: irq=%b pready=%b pslverr=%b prdata=%08h expected all 0",
               irq, pready, pslverr, prdata);
    end
    psel = 0; penable = 0;
    idle(2);
    rst_n = 1;
    strays = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (pready !== 1'b0) strays++;
    end
    checks++;
    if (strays != 0) begin
      errors++;
      $display("FAIL rdwait_stray_pready: %0d cycles with pready, expected 0", strays);
    end
    apb(0, 32'h00, 0, 0, rd, err, cyc);
    checks++;
    if (rd !== 32'd868 || cyc !== 2) begin
      errors++;
      $display("FAIL rdwait_recover: data=%0d cycles=%0d expected 868/2", rd, cyc);
    end
  endtask

  initial begin
    test_reset();
    test_ctrl();
    test_random_rw();
    test_status_irq();
    test_counters();
    test_slverr();
    test_reset_rd_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
